// File: rtl/rv32i_regfile_arb_if.sv
// Debug/host register-access bus between a requester and rv32i_regfile_arb.
// The requester owns req/we/pc_sel/addr/wdata; the arbiter answers with ack/rdata.
interface rv32i_regfile_arb_if;
  logic        req;
  logic        we;
  logic        pc_sel;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, pc_sel, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, pc_sel, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/rv32i_regfile_arb.sv
// Arbiter between the RV32I pipeline and a debug port for register file / PC access.
// Optional macro RV32I_REGARB_PC_ACCESS_EN enables PC reads/writes through dbg.pc_sel.
module rv32i_regfile_arb #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  core_rs1_idx,
  input  logic [4:0]  core_rs2_idx,
  input  logic [4:0]  core_rd_idx,
  input  logic [31:0] core_new_rd,
  input  logic [31:0] core_new_pc,
  input  logic        core_update_pc,
  input  logic        core_stall,
  output logic        core_hold,
  output logic [4:0]  rf_rs1_idx,
  output logic [4:0]  rf_rs2_idx,
  output logic [4:0]  rf_rd_idx,
  output logic [31:0] rf_new_rd,
  output logic [31:0] rf_new_pc,
  output logic        rf_update_pc,
  output logic        rf_stall,
  input  logic [31:0] rf_rs1,
  input  logic [31:0] rf_pc,
  rv32i_regfile_arb_if.slave dbg
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ACCESS,
    CAPTURE,
    ACK,
    RELEASE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  drain_cnt;
  logic        drain_done;
  logic        lat_we;
  logic        lat_pc_sel;
  logic [4:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] saved_pc;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        pc_access;

  assign drain_done = (drain_cnt == 3'(DRAIN_CYCLES - 1));

`ifdef RV32I_REGARB_PC_ACCESS_EN
  assign pc_access = lat_pc_sel;
`else
  // pc_sel is latched for a uniform datapath but never steers the access here.
  assign pc_access = 1'b0 & lat_pc_sel;
`endif

  always_comb begin
    next_state   = state;
    rf_rs1_idx   = core_rs1_idx;
    rf_rs2_idx   = core_rs2_idx;
    rf_rd_idx    = core_rd_idx;
    rf_new_rd    = core_new_rd;
    rf_new_pc    = core_new_pc;
    rf_update_pc = core_update_pc;
    rf_stall     = core_stall;

    case (state)
      IDLE: begin
        if (dbg.req) next_state = DRAIN;
      end

      DRAIN: begin
        rf_stall     = 1'b1;
        rf_update_pc = 1'b0;
        if (drain_done) next_state = ACCESS;
      end

      ACCESS: begin
        rf_rd_idx    = 5'd0;
        rf_stall     = 1'b1;
        rf_update_pc = 1'b0;
        if (lat_we) begin
          // The register file adds 4 after a PC update, so we pre-subtract it.
          rf_stall     = 1'b0;
          rf_update_pc = 1'b1;
          if (pc_access) begin
            rf_new_pc = lat_wdata - 32'd4;
          end else begin
            rf_rd_idx = lat_addr;
            rf_new_rd = lat_wdata;
            rf_new_pc = saved_pc - 32'd4;
          end
          next_state = ACK;
        end else begin
          if (!pc_access) rf_rs1_idx = lat_addr;
          next_state = CAPTURE;
        end
      end

      CAPTURE: begin
        if (!pc_access) rf_rs1_idx = lat_addr;
        rf_rd_idx    = 5'd0;
        rf_stall     = 1'b1;
        rf_update_pc = 1'b0;
        next_state   = ACK;
      end

      ACK: begin
        rf_rd_idx    = 5'd0;
        rf_stall     = 1'b1;
        rf_update_pc = 1'b0;
        next_state   = RELEASE;
      end

      RELEASE: begin
        rf_rd_idx    = 5'd0;
        rf_stall     = 1'b1;
        rf_update_pc = 1'b0;
        if (!dbg.req) next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      core_hold  <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'h0;
      saved_pc   <= RESET_VECTOR;
      drain_cnt  <= 3'd0;
      lat_we     <= 1'b0;
      lat_pc_sel <= 1'b0;
      lat_addr   <= 5'd0;
      lat_wdata  <= 32'h0;
    end else begin
      state     <= next_state;
      core_hold <= (next_state != IDLE);
      ack_q     <= (next_state == ACK);

      if (state == IDLE && dbg.req) begin
        lat_we     <= dbg.we;
        lat_pc_sel <= dbg.pc_sel;
        lat_addr   <= dbg.addr;
        lat_wdata  <= dbg.wdata;
        drain_cnt  <= 3'd0;
      end

      if (state == DRAIN) begin
        saved_pc <= rf_pc;
        if (!drain_done) drain_cnt <= drain_cnt + 3'd1;
      end

      if (state == CAPTURE) rdata_q <= pc_access ? saved_pc : rf_rs1;
    end
  end

  assign dbg.ack   = ack_q;
  assign dbg.rdata = rdata_q;

endmodule

// File: tb/tb_rv32i_regfile_arb.sv
// Randomized self-checking bench for rv32i_regfile_arb with a register file environment
// and a transaction-level expectation model (register contents, PC, read data, latency).
module tb_rv32i_regfile_arb;
  localparam int DRAIN = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  core_rs1_idx, core_rs2_idx, core_rd_idx;
  logic [31:0] core_new_rd, core_new_pc;
  logic        core_update_pc, core_stall;
  logic        core_hold;
  logic [4:0]  rf_rs1_idx, rf_rs2_idx, rf_rd_idx;
  logic [31:0] rf_new_rd, rf_new_pc;
  logic        rf_update_pc, rf_stall;
  logic [31:0] rf_rs1, rf_pc;

  int total = 0;
  int bad = 0;

  logic [31:0] regs [32] = '{default: 32'h0};
  logic [31:0] pc_q = 32'h0;

  logic [31:0] exp_regs [32];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  rv32i_regfile_arb_if dbg_bus ();

  rv32i_regfile_arb #(
    .RESET_VECTOR (32'h0000_0100),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .core_rs1_idx   (core_rs1_idx),
    .core_rs2_idx   (core_rs2_idx),
    .core_rd_idx    (core_rd_idx),
    .core_new_rd    (core_new_rd),
    .core_new_pc    (core_new_pc),
    .core_update_pc (core_update_pc),
    .core_stall     (core_stall),
    .core_hold      (core_hold),
    .rf_rs1_idx     (rf_rs1_idx),
    .rf_rs2_idx     (rf_rs2_idx),
    .rf_rd_idx      (rf_rd_idx),
    .rf_new_rd      (rf_new_rd),
    .rf_new_pc      (rf_new_pc),
    .rf_update_pc   (rf_update_pc),
    .rf_stall       (rf_stall),
    .rf_rs1         (rf_rs1),
    .rf_pc          (rf_pc),
    .dbg            (dbg_bus.slave)
  );

  // Register file environment: writes land whenever rd is nonzero, PC steps only when not stalled.
  always @(posedge clk) begin
    if (rf_rd_idx != 5'd0) regs[rf_rd_idx] <= rf_new_rd;
    if (!rf_stall) pc_q <= (rf_update_pc ? rf_new_pc : pc_q) + 32'd4;
  end
  assign rf_rs1 = regs[rf_rs1_idx];
  assign rf_pc  = pc_q;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] new_rd, input logic [31:0] new_pc,
                               input logic upd, input logic stall);
    core_rs1_idx   = rs1;
    core_rs2_idx   = rs2;
    core_rd_idx    = rd;
    core_new_rd    = new_rd;
    core_new_pc    = new_pc;
    core_update_pc = upd;
    core_stall     = stall;
    if (rd != 5'd0) exp_regs[rd] = new_rd;
  endtask

  task automatic idleCycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] new_rd, input logic [31:0] new_pc,
                           input logic upd, input logic stall);
    @(negedge clk);
    applyStimulus(rs1, rs2, rd, new_rd, new_pc, upd, stall);
    #1;
    checkOutput("pass_rs1", 32'(rf_rs1_idx), 32'(rs1));
    checkOutput("pass_rs2", 32'(rf_rs2_idx), 32'(rs2));
    checkOutput("pass_rd", 32'(rf_rd_idx), 32'(rd));
    checkOutput("pass_new_rd", rf_new_rd, new_rd);
    checkOutput("pass_new_pc", rf_new_pc, new_pc);
    checkOutput("pass_upd", 32'(rf_update_pc), 32'(upd));
    checkOutput("pass_stall", 32'(rf_stall), 32'(stall));
    checkOutput("idle_hold", 32'(core_hold), 32'h0);
  endtask

  task automatic runTransaction(input logic we, input logic pc_sel, input logic [4:0] addr,
                                input logic [31:0] wdata, input logic [4:0] c_rd,
                                input logic [31:0] c_data, input logic drop_early);
    int cnt;
    logic got_ack;
    logic pc_acc;
    logic [31:0] exp_pc;
    int want_lat;
`ifdef RV32I_REGARB_PC_ACCESS_EN
    pc_acc = pc_sel;
`else
    pc_acc = 1'b0;
`endif
    @(negedge clk);
    applyStimulus(5'd1, 5'd2, c_rd, c_data, 32'h0, 1'b0, 1'b1);
    dbg_bus.req    = 1'b1;
    dbg_bus.we     = we;
    dbg_bus.pc_sel = pc_sel;
    dbg_bus.addr   = addr;
    dbg_bus.wdata  = wdata;
    exp_pc   = rf_pc;
    want_lat = we ? DRAIN + 2 : DRAIN + 3;
    cnt = 0;
    got_ack = 1'b0;
    while (!got_ack && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        // Core keeps asking for a branch and no stall; the arbiter must override it.
        applyStimulus(5'd3, 5'd4, 5'd0, 32'h0, 32'h0BAD_0000, 1'b1, 1'b0);
        if (drop_early) dbg_bus.req = 1'b0;
        #1;
      end
      checkOutput("hold", 32'(core_hold), 32'h1);
      if (dbg_bus.ack) begin
        got_ack = 1'b1;
      end else if (cnt <= DRAIN) begin
        checkOutput("drain_stall", 32'(rf_stall), 32'h1);
        checkOutput("drain_upd", 32'(rf_update_pc), 32'h0);
      end else if (cnt == DRAIN + 1) begin
        if (we) begin
          checkOutput("acc_upd", 32'(rf_update_pc), 32'h1);
          checkOutput("acc_stall", 32'(rf_stall), 32'h0);
          checkOutput("acc_new_pc", rf_new_pc, (pc_acc ? wdata : exp_pc) - 32'd4);
          checkOutput("acc_rd", 32'(rf_rd_idx), pc_acc ? 32'h0 : 32'(addr));
        end else begin
          checkOutput("acc_rd_rd", 32'(rf_rd_idx), 32'h0);
          checkOutput("acc_rd_stall", 32'(rf_stall), 32'h1);
        end
      end else begin
        checkOutput("cap_rd", 32'(rf_rd_idx), 32'h0);
      end
    end
    checkOutput("ack_latency", 32'(cnt), 32'(want_lat));
    if (we) begin
      if (pc_acc) exp_pc = wdata;
      else if (addr != 5'd0) exp_regs[addr] = wdata;
    end else begin
      exp_rdata = pc_acc ? exp_pc : exp_regs[addr];
    end
    checkOutput("rdata", dbg_bus.rdata, exp_rdata);
    @(negedge clk);
    dbg_bus.req = 1'b0;
    checkOutput("ack_pulse", 32'(dbg_bus.ack), 32'h0);
    checkOutput("release_hold", 32'(core_hold), 32'h1);
    checkOutput("pc_after", rf_pc, exp_pc);
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("hold_drop", 32'(core_hold), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    exp_rdata = 32'h0;
    dbg_bus.req    = 1'b0;
    dbg_bus.we     = 1'b0;
    dbg_bus.pc_sel = 1'b0;
    dbg_bus.addr   = 5'd0;
    dbg_bus.wdata  = 32'h0;
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_hold", 32'(core_hold), 32'h0);
    checkOutput("rst_ack", 32'(dbg_bus.ack), 32'h0);
    checkOutput("rst_rdata", dbg_bus.rdata, 32'h0);
    reset_n = 1'b1;

    $display("[TB] directed sequence");
    idleCycle(5'd1, 5'd2, 5'd5, 32'h1234, 32'h40, 1'b0, 1'b1);
    runTransaction(1'b1, 1'b0, 5'd10, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0);
    runTransaction(1'b0, 1'b0, 5'd10, 32'h0, 5'd0, 32'h0, 1'b0);
    idleCycle(5'd0, 5'd0, 5'd7, 32'h0000_00A5, 32'h0, 1'b0, 1'b1);
    runTransaction(1'b0, 1'b0, 5'd7, 32'h0, 5'd0, 32'h0, 1'b0);
    runTransaction(1'b0, 1'b0, 5'd3, 32'h0, 5'd3, 32'h55, 1'b0);
    runTransaction(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1);
    runTransaction(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    runTransaction(1'b0, 1'b0, 5'd10, 32'h0, 5'd0, 32'h0, 1'b0);

    $display("[TB] reset during CAPTURE");
    @(negedge clk);
    dbg_bus.req  = 1'b1;
    dbg_bus.we   = 1'b0;
    dbg_bus.addr = 5'd7;
    repeat (DRAIN + 2) @(negedge clk);
    reset_n = 1'b0;
    dbg_bus.req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_rdata = 32'h0;
    checkOutput("midrst_hold", 32'(core_hold), 32'h0);
    checkOutput("midrst_ack", 32'(dbg_bus.ack), 32'h0);
    checkOutput("midrst_rdata", dbg_bus.rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_ack", 32'(dbg_bus.ack), 32'h0);
    end

    $display("[TB] randomized sequence");
    for (int t = 0; t < 40; t++) begin
      int n_idle;
      logic [4:0] a;
      n_idle = $urandom_range(1, 3);
      for (int k = 0; k < n_idle; k++) begin
        idleCycle(5'($urandom), 5'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  1'($urandom), 1'($urandom));
      end
      a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      runTransaction(1'($urandom), 1'($urandom), a, $urandom,
                     ($urandom_range(0, 2) == 0) ? a : 5'd0, $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_regfile_arb.md
Name: rv32i_regfile_arb

Overview:
- Arbiter between the RV32I pipeline and a debug/host register-access port for the single-HART register file and PC.
- Sits between the decode/ALU stages and the register file.
- In IDLE, all pipeline signals pass straight through.
- On a debug request, it freezes the pipeline, drains the final write, performs one GPR read or write via the register file ports, then acknowledges and releases.

Parameters:
- RESET_VECTOR, 32'h00000000, reset PC value; used only to initialise the saved-PC register.
- DRAIN_CYCLES, 1, cycles held in DRAIN after hold assertion (1..7) so in-flight writebacks land.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- core_rs1_idx  input  5  pipeline RS1 index
- core_rs2_idx  input  5  pipeline RS2 index
- core_rd_idx  input  5  pipeline RD index
- core_new_rd  input  32  pipeline writeback data
- core_new_pc  input  32  pipeline branch target
- core_update_pc  input  1  pipeline branch-taken
- core_stall  input  1  pipeline stall request
- core_hold  output  1  freeze request to pipeline (registered)
- rf_rs1_idx  output  5  to register file
- rf_rs2_idx  output  5  to register file
- rf_rd_idx  output  5  to register file
- rf_new_rd  output  32  to register file
- rf_new_pc  output  32  to register file
- rf_update_pc  output  1  to register file
- rf_stall  output  1  to register file
- rf_rs1  input  32  register file RS1 read data
- rf_pc  input  32  register file current PC
- dbg_req  input  1  access request, level, held until ack
- dbg_we  input  1  1=write, 0=read; sampled with req
- dbg_pc_sel  input  1  PC access select (see Optional Feature)
- dbg_addr  input  5  GPR index
- dbg_wdata  input  32  write data
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  32  read result, held until next read completes

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, core_hold=0, dbg_ack=0, dbg_rdata=0, saved_pc=RESET_VECTOR, drain counter=0. Reset mid-transaction aborts it with no ack; the requester must re-issue.
- States: IDLE, DRAIN, ACCESS, CAPTURE, ACK, RELEASE.
- IDLE:
  - rf_* = core_* and rf_stall = core_stall; no added latency.
  - dbg_req=1 moves to DRAIN; dbg_we, dbg_pc_sel, dbg_addr and dbg_wdata are latched at this edge.
- DRAIN:
  - core_hold=1; rf_stall=1; rf_update_pc=0.
  - rf_rd_idx/rf_new_rd still pass core values so the last writeback retires.
  - saved_pc<=rf_pc each cycle.
  - After DRAIN_CYCLES cycles, moves to ACCESS.
- ACCESS, write:
  - rf_rd_idx=latched addr; rf_new_rd=wdata; rf_stall=0.
  - rf_update_pc=1 with rf_new_pc=saved_pc-4, so PC is unchanged after the +4.
  - Next state ACK.
- ACCESS, read:
  - rf_rs1_idx=latched addr; rf_rd_idx=0; rf_stall=1.
  - Next state CAPTURE.
- CAPTURE:
  - rf_rd_idx=0, which suppresses register file forwarding.
  - dbg_rdata<=rf_rs1 (one-cycle read latency).
  - Next state ACK.
- ACK: dbg_ack=1 for exactly one cycle; rf_stall=1. Next state RELEASE.
- RELEASE:
  - Holds until dbg_req=0, then goes to IDLE; core_hold deasserts on that transition.
  - Back-to-back requests therefore see at least one IDLE cycle.
- Writes to x0 still complete and ack, but the register file stays 0. Reads of x0 return 0.
- dbg_req dropping before ack is ignored; the transaction completes.
- Minimum latency, req to ack: write = DRAIN_CYCLES+2; read = DRAIN_CYCLES+3.
- PC arithmetic is modulo 2^32; saved_pc=0 gives rf_new_pc=32'hFFFFFFFC.

Optional Feature:
- Macro: RV32I_REGARB_PC_ACCESS_EN.
- Defined, dbg_pc_sel=1:
  - Read: dbg_rdata<=saved_pc in CAPTURE, with no register file read.
  - Write: in ACCESS, rf_update_pc=1, rf_new_pc=dbg_wdata-4, rf_rd_idx=0; the new PC is dbg_wdata.
- Undefined: dbg_pc_sel is ignored and the access is always a GPR access; the port is kept for a stable interface.

Test Plan:
- Idle pass-through: core_rd_idx=5, core_new_rd=32'h1234, no dbg_req -> rf_rd_idx=5, rf_new_rd=32'h1234 in the same cycle; core_hold=0.
- Debug write: dbg_req, we=1, addr=10, wdata=32'hDEADBEEF, DRAIN_CYCLES=1 -> ack on the 3rd cycle after req; x10 reads 32'hDEADBEEF; rf_pc unchanged across the access.
- Debug read: x7=32'h0000_00A5 -> dbg_rdata=32'h0000_00A5 at ack, 4 cycles after req; no write lands, since rf_rd_idx=0 in ACCESS and CAPTURE.
- Drain: a core writeback to x3=32'h55 in the req cycle, then a read of x3 -> dbg_rdata=32'h55.
- x0 write: write 32'hFFFFFFFF to x0 -> ack pulses; a subsequent read of x0 returns 0.
- Reset in CAPTURE: reset_n=0 for one cycle -> state IDLE, dbg_ack never asserted, core_hold=0, dbg_rdata=0.
